// File: rtl/hazard_stall_ctrl_if.sv
// Hazard controller bundle: pipeline stage fields fed back to the controller
// and the stall/flush/hold controls it returns. The pipeline side is the
// master and the controller is the slave.
interface hazard_stall_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs2;
  logic       ex_memread;
  logic [4:0] ex_rd;
  logic       ex_branch_taken;
  logic       mem_req;
  logic       mem_ready;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_flush;
  logic       idex_hold;
  logic       exmem_hold;
  logic       mem_err;
  logic [1:0] state;

  modport master (
    output id_rs1, id_rs2, id_uses_rs2, ex_memread, ex_rd, ex_branch_taken,
           mem_req, mem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_flush, idex_hold, exmem_hold,
           mem_err, state
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs2, ex_memread, ex_rd, ex_branch_taken,
           mem_req, mem_ready,
    output pc_write, ifid_write, ifid_flush, idex_flush, idex_hold, exmem_hold,
           mem_err, state
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard sequencer for the IF/ID and ID/EX buffers.
// Handles load-use bubbles, taken-branch flushes and data-memory wait states.
// Priority in every state: memory wait > taken branch > load-use.
// Control outputs are combinational from the state and the current inputs so
// a stall or flush takes effect in the same cycle it is detected.
// Optional build macro HAZARD_PERF_CNT_EN adds stall/flush cycle counters.
module hazard_stall_ctrl #(
  parameter int unsigned LU_BUBBLES   = 1,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic               clk,
  input  logic               reset,
  hazard_stall_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        flush_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_BR_FLUSH = 2'd2,
    ST_MEM_WAIT = 2'd3
  } state_t;

  localparam logic [3:0]  LU_INIT = 4'(LU_BUBBLES - 1);
  localparam logic [3:0]  FL_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

  state_t      state_r, state_nxt_s;
  state_t      ret_state_r, ret_nxt_s;
  logic [3:0]  cnt_r, cnt_nxt_s;
  logic [15:0] wcnt_r, wcnt_nxt_s;
  logic        mem_err_r, err_nxt_s;
  logic        lu_hit_s, mwait_s;
  logic        pc_write_s, ifid_write_s, ifid_flush_s, idex_flush_s;
  logic        idex_hold_s, exmem_hold_s;

  assign lu_hit_s = hz.ex_memread & (hz.ex_rd != 5'd0) &
                    ((hz.ex_rd == hz.id_rs1) | (hz.id_uses_rs2 & (hz.ex_rd == hz.id_rs2)));
  assign mwait_s  = hz.mem_req & ~hz.mem_ready;

  // Next-state decode and raw control outputs for the current state and inputs.
  always_comb begin
    pc_write_s   = 1'b0;
    ifid_write_s = 1'b0;
    ifid_flush_s = 1'b0;
    idex_flush_s = 1'b0;
    idex_hold_s  = 1'b0;
    exmem_hold_s = 1'b0;
    state_nxt_s  = state_r;
    ret_nxt_s    = ret_state_r;
    cnt_nxt_s    = cnt_r;
    wcnt_nxt_s   = wcnt_r;
    err_nxt_s    = mem_err_r;
    case (state_r)
      ST_RUN: begin
        if (mwait_s) begin
          idex_hold_s  = 1'b1;
          exmem_hold_s = 1'b1;
          ret_nxt_s    = ST_RUN;
          wcnt_nxt_s   = 16'd1;
          state_nxt_s  = ST_MEM_WAIT;
        end else if (hz.ex_branch_taken) begin
          pc_write_s   = 1'b1;
          ifid_write_s = 1'b1;
          ifid_flush_s = 1'b1;
          idex_flush_s = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            cnt_nxt_s   = FL_INIT;
            state_nxt_s = ST_BR_FLUSH;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else if (lu_hit_s) begin
          idex_flush_s = 1'b1;
          if (LU_BUBBLES > 1) begin
            cnt_nxt_s   = LU_INIT;
            state_nxt_s = ST_LU_STALL;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          pc_write_s   = 1'b1;
          ifid_write_s = 1'b1;
        end
      end
      ST_LU_STALL, ST_BR_FLUSH: begin
        if (mwait_s) begin
          // Counter stays frozen so the stall/flush resumes where it left off.
          idex_hold_s  = 1'b1;
          exmem_hold_s = 1'b1;
          ret_nxt_s    = state_r;
          wcnt_nxt_s   = 16'd1;
          state_nxt_s  = ST_MEM_WAIT;
        end else begin
          if (state_r == ST_BR_FLUSH) begin
            ifid_write_s = 1'b1;
            ifid_flush_s = 1'b1;
          end else begin
            ifid_flush_s = 1'b0;
          end
          idex_flush_s = 1'b1;
          cnt_nxt_s    = cnt_r - 4'd1;
          if (cnt_r == 4'd1) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = state_r;
          end
        end
      end
      ST_MEM_WAIT: begin
        idex_hold_s  = 1'b1;
        exmem_hold_s = 1'b1;
        wcnt_nxt_s   = wcnt_r + 16'd1;
        if (hz.mem_ready) begin
          state_nxt_s = ret_state_r;
        end else if (wcnt_r == TIMEOUT) begin
          err_nxt_s   = 1'b1;
          state_nxt_s = ret_state_r;
        end else begin
          state_nxt_s = ST_MEM_WAIT;
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
      end
    endcase
  end

  // Drive the controls, forcing a flushed/frozen-PC pipeline while reset is low.
  always_comb begin
    if (!reset) begin
      hz.pc_write   = 1'b0;
      hz.ifid_write = 1'b0;
      hz.ifid_flush = 1'b1;
      hz.idex_flush = 1'b1;
      hz.idex_hold  = 1'b0;
      hz.exmem_hold = 1'b0;
    end else begin
      hz.pc_write   = pc_write_s;
      hz.ifid_write = ifid_write_s;
      hz.ifid_flush = ifid_flush_s;
      hz.idex_flush = idex_flush_s;
      hz.idex_hold  = idex_hold_s;
      hz.exmem_hold = exmem_hold_s;
    end
  end

  assign hz.state   = state_r;
  assign hz.mem_err = mem_err_r;

  // Sequencer state, return state, counters and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_RUN;
      ret_state_r <= ST_RUN;
      cnt_r       <= 4'd0;
      wcnt_r      <= 16'd0;
      mem_err_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      ret_state_r <= ret_nxt_s;
      cnt_r       <= cnt_nxt_s;
      wcnt_r      <= wcnt_nxt_s;
      mem_err_r   <= err_nxt_s;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_r;
  logic [31:0] flush_cycles_r;

  // Count PC-stalled and IF/ID-flushed cycles outside reset; both wrap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cycles_r <= 32'd0;
      flush_cycles_r <= 32'd0;
    end else begin
      if (!pc_write_s) begin
        stall_cycles_r <= stall_cycles_r + 32'd1;
      end else begin
        stall_cycles_r <= stall_cycles_r;
      end
      if (ifid_flush_s) begin
        flush_cycles_r <= flush_cycles_r + 32'd1;
      end else begin
        flush_cycles_r <= flush_cycles_r;
      end
    end
  end

  assign stall_cycles = stall_cycles_r;
  assign flush_cycles = flush_cycles_r;
`endif

endmodule
